// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM encodings for the bit-serial ALU, plus
// small decode helpers used by the top level and the bit slice.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_INC = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_DEC = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_NOT = 3'd7;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_ARITH = 3'd0,
    CLS_AND   = 3'd1,
    CLS_OR    = 3'd2,
    CLS_XOR   = 3'd3,
    CLS_NOT   = 3'd4
  } op_class_e;

  function automatic op_class_e op_class(input logic [2:0] op);
    case (op)
      ALU_AND: return CLS_AND;
      ALU_OR:  return CLS_OR;
      ALU_XOR: return CLS_XOR;
      ALU_NOT: return CLS_NOT;
      default: return CLS_ARITH;
    endcase
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // Subtract-style ops report borrow, i.e. the inverted adder carry.
  function automatic logic is_borrow_op(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_DEC);
  endfunction

  function automatic logic carry_init(input logic [2:0] op);
    return (op == ALU_INC) || (op == ALU_SUB);
  endfunction

  function automatic logic operand_bit(input logic [2:0] op, input logic b_bit);
    case (op)
      ALU_ADD: return b_bit;
      ALU_INC: return 1'b0;
      ALU_SUB: return ~b_bit;
      ALU_DEC: return 1'b1;
      default: return b_bit;
    endcase
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU datapath: full adder for arithmetic ops, bitwise gate otherwise.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic      a_bit,
  input  logic      bop_bit,
  input  logic      carry_in,
  input  op_class_e op_cls,
  output logic      result_bit,
  output logic      carry_out
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    result_bit = 1'b0;
    carry_out  = 1'b0;
    case (op_cls)
      CLS_ARITH: begin
        result_bit = a_bit ^ bop_bit ^ carry_in;
        carry_out  = (a_bit & bop_bit) | (a_bit & carry_in) | (bop_bit & carry_in);
      end
      CLS_AND: result_bit = a_bit & bop_bit;
      CLS_OR:  result_bit = a_bit | bop_bit;
      CLS_XOR: result_bit = a_bit ^ bop_bit;
      CLS_NOT: result_bit = ~a_bit;
      default: result_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial handshaked ALU: accepts A/B/opcode, computes one bit per cycle LSB
// first, then presents Result and NZVC until the consumer takes them.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       NZVC
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       nzvc_q, nzvc_d;
  logic             out_valid_q, out_valid_d;

  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] final_res;
  logic             arith;

  alu_bit_slice u_slice (
    .a_bit      (a_q[0]),
    .bop_bit    (operand_bit(op_q, b_q[0])),
    .carry_in   (carry_q),
    .op_cls     (op_class(op_q)),
    .result_bit (sum_bit),
    .carry_out  (carry_out)
  );

  // The bit produced this cycle lands in the MSB; earlier bits shift down.
  assign final_res = {sum_bit, acc_q[WIDTH-1:1]};
  assign arith     = is_arith(op_q);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    result_d    = result_q;
    nzvc_d      = nzvc_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          op_d    = ALU_Sel;
          cnt_d   = '0;
          carry_d = carry_init(ALU_Sel);
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = final_res;
        carry_d = carry_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d          = DONE;
          out_valid_d      = 1'b1;
          result_d         = final_res;
          nzvc_d[FLAG_N]   = sum_bit;
          nzvc_d[FLAG_Z]   = (final_res == '0);
          // carry_q still holds the carry into the MSB here.
          nzvc_d[FLAG_V]   = arith & (carry_q ^ carry_out);
          nzvc_d[FLAG_C]   = arith & (carry_out ^ is_borrow_op(op_q));
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= ALU_ADD;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      nzvc_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      nzvc_q      <= nzvc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign NZVC      = nzvc_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed self-checking bench for alu_serial with hand-computed results.
module tb_alu_serial;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [2:0] ALU_Sel = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] Result;
  logic [3:0] NZVC;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] res;
    logic [3:0] f;
  } vec_t;

  alu_serial #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .NZVC      (NZVC)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, holds it until accepted, then scrambles the inputs.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    int guard;
    in_valid = 1'b1;
    A = a;
    B = b;
    ALU_Sel = sel;
    guard = 0;
    while (!in_ready && guard < 30) begin
      tick();
      guard++;
    end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_accept: in_ready stuck low, got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    A = 8'h5A;
    B = 8'hC3;
    ALU_Sel = 3'd7;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || Result !== 8'h00 || NZVC !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h nzvc=%b expected 0 0 00 0000",
               in_ready, out_valid, Result, NZVC);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    vec_t v[9];
    int lat;
    v[0] = '{"add_100_30",   8'd100, 8'd30,  ALU_ADD, 8'h82, 4'b1010};
    v[1] = '{"inc_127",      8'd127, 8'hFF,  ALU_INC, 8'h80, 4'b1010};
    v[2] = '{"dec_m128",     8'h80,  8'h00,  ALU_DEC, 8'h7F, 4'b0010};
    v[3] = '{"dec_0",        8'h00,  8'h33,  ALU_DEC, 8'hFF, 4'b1001};
    v[4] = '{"sub_17_40",    8'd17,  8'd40,  ALU_SUB, 8'hE9, 4'b1001};
    // 73 - (-93) = 166 overflows; unsigned 0x49 < 0xA3 so borrow is set too.
    v[5] = '{"sub_73_m93",   8'd73,  8'hA3,  ALU_SUB, 8'hA6, 4'b1011};
    v[6] = '{"and_0_m1",     8'h00,  8'hFF,  ALU_AND, 8'h00, 4'b0100};
    v[7] = '{"not_m1",       8'hFF,  8'h12,  ALU_NOT, 8'h00, 4'b0100};
    v[8] = '{"xor_78_121",   8'd78,  8'd121, ALU_XOR, 8'h37, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      send(v[i].a, v[i].b, v[i].sel);
      wait_out(lat);
      n_tests++;
      if (lat !== 8) begin
        n_fail++;
        $display("FAIL %s latency: got %0d expected 8", v[i].name, lat);
      end
      n_tests++;
      if (Result !== v[i].res || NZVC !== v[i].f) begin
        n_fail++;
        $display("FAIL %s result: got %h/%b expected %h/%b",
                 v[i].name, Result, NZVC, v[i].res, v[i].f);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || Result !== v[i].res || NZVC !== v[i].f) begin
        n_fail++;
        $display("FAIL %s after_handoff: got vld=%b rdy=%b res=%h nzvc=%b expected 0 1 %h %b",
                 v[i].name, out_valid, in_ready, Result, NZVC, v[i].res, v[i].f);
      end
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    send(8'd100, 8'd30, ALU_ADD);
    wait_out(lat);
    in_valid = 1'b1;
    A = 8'd3;
    B = 8'd4;
    ALU_Sel = ALU_ADD;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Result !== 8'h82 || NZVC !== 4'b1010) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%h nzvc=%b expected 1 0 82 1010",
                 i, out_valid, in_ready, Result, NZVC);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_handoff: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    n_tests++;
    if (lat !== 8 || Result !== 8'h07 || NZVC !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_second: got lat=%0d res=%h nzvc=%b expected 8 07 0000",
               lat, Result, NZVC);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_ready_high();
    int lat;
    out_ready = 1'b1;
    send(8'h0F, 8'hF0, ALU_OR);
    wait_out(lat);
    n_tests++;
    if (lat !== 8 || Result !== 8'hFF || NZVC !== 4'b1000) begin
      n_fail++;
      $display("FAIL rdy_high_result: got lat=%0d res=%h nzvc=%b expected 8 ff 1000",
               lat, Result, NZVC);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_high_pulse: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    send(8'd17, 8'd40, ALU_SUB);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (Result !== 8'h00 || NZVC !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got res=%h nzvc=%b vld=%b rdy=%b expected 00 0000 0 0",
               Result, NZVC, out_valid, in_ready);
    end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0 || Result !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_no_valid: got seen=%b res=%h expected 0 00", seen, Result);
    end
    send(8'd1, 8'd5, ALU_ADD);
    wait_out(lat);
    n_tests++;
    if (lat !== 8 || Result !== 8'h06 || NZVC !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_add: got lat=%0d res=%h nzvc=%b expected 8 06 0000",
               lat, Result, NZVC);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_pressure();
    test_ready_high();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
